// File: rtl/edge_detect_mc_if.sv
// Channel bundle for edge_detect_mc: raw inputs and controls in, debounced levels and events out.
interface edge_detect_mc_if #(
  parameter int N      = 8,
  parameter int FILT_W = 4
);
  logic [N-1:0]      din;
  logic [2*N-1:0]    mode;
  logic [FILT_W-1:0] filt_len;
  logic [N-1:0]      clr;
  logic [N-1:0]      level;
  logic [N-1:0]      pulse;
  logic [N-1:0]      sticky;
  logic              irq;

  modport master (
    output din, mode, filt_len, clr,
    input  level, pulse, sticky, irq
  );

  modport slave (
    input  din, mode, filt_len, clr,
    output level, pulse, sticky, irq
  );
endinterface

// File: rtl/edge_detect_mc.sv
// Multi-channel glitch-filtered edge detector with per-channel mode, sticky flags and irq.
// Optional EDGE_SYNC_EN adds a 2-flop input synchronizer per channel ahead of the filter.
module edge_detect_mc #(
  parameter int N      = 8,
  parameter int FILT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  edge_detect_mc_if.slave  bus
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_run;
  logic [N-1:0] w_s;
  logic [N-1:0] w_level;
  logic [N-1:0] w_pulse;
  logic [N-1:0] w_sticky;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT) w_state_nxt = ST_RUN;
  end

  always_comb begin
    w_run = (r_state == ST_RUN);
  end

`ifdef EDGE_SYNC_EN
  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.din;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = bus.din;
`endif

  for (genvar g = 0; g < N; g++) begin : g_lane
    edge_detect_mc_lane #(.FILT_W(FILT_W)) u_lane (
      .clk        (clk),
      .rstn       (rstn),
      .i_run      (w_run),
      .i_s        (w_s[g]),
      .i_mode     (bus.mode[2*g +: 2]),
      .i_filt_len (bus.filt_len),
      .i_clr      (bus.clr[g]),
      .o_level    (w_level[g]),
      .o_pulse    (w_pulse[g]),
      .o_sticky   (w_sticky[g])
    );
  end

  assign bus.level  = w_level;
  assign bus.pulse  = w_pulse;
  assign bus.sticky = w_sticky;
  assign bus.irq    = |w_sticky;

endmodule

// One channel: debounce counter, change capture, mode qualify, pulse and sticky flag.
module edge_detect_mc_lane #(
  parameter int FILT_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_run,
  input  logic              i_s,
  input  logic [1:0]        i_mode,
  input  logic [FILT_W-1:0] i_filt_len,
  input  logic              i_clr,
  output logic              o_level,
  output logic              o_pulse,
  output logic              o_sticky
);

  logic              r_level;
  logic [FILT_W-1:0] r_cnt;
  logic              r_chg;
  logic              r_dir;
  logic              r_pulse;
  logic              r_sticky;
  logic              w_accept;
  logic              w_qual;

  // Count only grows while below filt_len, so >= also covers a shrunk filt_len.
  assign w_accept = i_run && (i_s != r_level) && (r_cnt >= i_filt_len);

  // Direction is captured with the change so back-to-back changes qualify correctly.
  always_comb begin
    w_qual = 1'b0;
    case (i_mode)
      2'b01:   w_qual = r_dir;
      2'b10:   w_qual = ~r_dir;
      2'b11:   w_qual = 1'b1;
      default: w_qual = 1'b0;
    endcase
    w_qual = w_qual & r_chg;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_level  <= 1'b0;
      r_cnt    <= '0;
      r_chg    <= 1'b0;
      r_dir    <= 1'b0;
      r_pulse  <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_chg    <= w_accept;
      r_pulse  <= w_qual;
      r_sticky <= w_qual | (r_sticky & ~i_clr);
      if (w_accept) r_dir <= i_s;
      if (!i_run) begin
        r_level <= i_s;
        r_cnt   <= '0;
      end else if (i_s == r_level) begin
        r_cnt   <= '0;
      end else if (w_accept) begin
        r_level <= i_s;
        r_cnt   <= '0;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level  = r_level;
  assign o_pulse  = r_pulse;
  assign o_sticky = r_sticky;

endmodule
